// File: rtl/signed_number_32_bit_divider.sv
// Iterative signed 32-bit restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_ZERO_FASTPATH_EN: a zero divisor skips the iteration and finishes in two cycles.
module signed_number_32_bit_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  logic [32:0] r_div_mag;
  logic [31:0] r_dq;
  logic [32:0] r_rem;
  logic [4:0]  r_cnt;
  logic        r_sign_q;
  logic        r_sign_r;
  logic        r_b_zero;
  logic        r_ovf;
  logic [31:0] r_a_raw;

  logic [32:0] w_shift;
  logic        w_ge;
  logic [32:0] w_sub;

  // 33-bit magnitude so that -2^31 is represented exactly.
  function automatic logic [32:0] f_mag33(input logic [31:0] v);
    f_mag33 = v[31] ? (33'd0 - {1'b1, v}) : {1'b0, v};
  endfunction

  function automatic logic [31:0] f_apply_sign(input logic neg, input logic [32:0] mag);
    f_apply_sign = neg ? 32'(33'd0 - mag) : 32'(mag);
  endfunction

  // r_dq holds the remaining dividend bits on the left and the growing quotient on the right.
  assign w_shift = {r_rem[31:0], r_dq[31]};
  assign w_ge    = (w_shift >= r_div_mag);
  assign w_sub   = w_shift - r_div_mag;

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_div_mag   <= 33'd0;
      r_dq        <= 32'd0;
      r_rem       <= 33'd0;
      r_cnt       <= 5'd0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_b_zero    <= 1'b0;
      r_ovf       <= 1'b0;
      r_a_raw     <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div_mag <= f_mag33(b);
            r_dq      <= 32'(f_mag33(a));
            r_rem     <= 33'd0;
            r_cnt     <= 5'd31;
            r_sign_q  <= a[31] ^ b[31];
            r_sign_r  <= a[31];
            r_b_zero  <= (b == 32'd0);
            r_ovf     <= (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
            r_a_raw   <= a;
            busy      <= 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
            if (b == 32'd0) begin
              r_state <= S_FIX;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state   <= S_CALC;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (w_ge) begin
            r_rem <= w_sub;
          end else begin
            r_rem <= w_shift;
          end
          r_dq  <= {r_dq[30:0], w_ge};
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          // A zero divisor discards whatever the iteration produced.
          if (r_b_zero) begin
            quotient    <= 32'hFFFF_FFFF;
            remainder   <= r_a_raw;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            quotient    <= f_apply_sign(r_sign_q, {1'b0, r_dq});
            remainder   <= f_apply_sign(r_sign_r, r_rem);
            div_by_zero <= 1'b0;
            overflow    <= r_ovf;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
